// File: rtl/axi_ux_pkg.sv
// axi_ux_pkg: shared types and default widths for the AXI tile router.
//   ost_entry_t : one accepted-but-unfinished transaction (tile index,
//                 burst length minus one, unmapped flag).
//   make_entry  : packs the three fields into an ost_entry_t.
package axi_ux_pkg;

  localparam int AXI_INADR_DEF = 12;
  localparam int ADDR_TILE_DEF = 4;
  localparam int TILES_DEF     = 16;
  localparam int OUTSTND_DEF   = 4;

  // Index field is stored at a fixed width so the entry layout does not
  // depend on the router's parameters; ADDR_TILE may be at most IDX_W.
  localparam int IDX_W = 8;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [7:0]       alen;
    logic             unmapped;
  } ost_entry_t;

  localparam int ENTRY_W = $bits(ost_entry_t);

  function automatic ost_entry_t make_entry(input logic [IDX_W-1:0] idx,
                                            input logic [7:0]       alen,
                                            input logic             unmapped);
    ost_entry_t e;
    e.idx      = idx;
    e.alen     = alen;
    e.unmapped = unmapped;
    return e;
  endfunction

endpackage

// File: rtl/axi_ux_fifo.sv
// axi_ux_fifo: ordered queue of outstanding transactions.
//   clk, rst_n  : clock, synchronous active-low reset (clears pointers/count)
//   push, din   : write request and data (ignored while full)
//   pop, dout   : read request (ignored while empty) and head entry
//   full, empty : occupancy flags
//   count       : number of stored entries, 0..DEPTH
module axi_ux_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  // A full queue refuses writes even when the head leaves in the same cycle.
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/axi_ux_route.sv
// axi_ux_route: routes AXI address/data bursts to one of TILES tile ports.
//   clk, rst_n                       : clock, synchronous active-low reset
//   AXI_ADDR/ALEN/AVALID, AXI_AREADY : upstream address channel
//   AXI_VALID, AXI_READY, AXI_LAST   : upstream data channel
//   tile_AXI_AVALID/AREADY           : per-tile address handshake
//   tile_AXI_VALID/READY             : per-tile data handshake
//   dec_err                          : one-cycle pulse after an unmapped address
//   outstanding                      : accepted-but-unfinished transactions
// Data beats always belong to the oldest outstanding address; unmapped
// bursts are absorbed locally.
module axi_ux_route
  import axi_ux_pkg::*;
#(
  parameter int AXI_INADR = AXI_INADR_DEF,
  parameter int ADDR_TILE = ADDR_TILE_DEF,
  parameter int TILES     = TILES_DEF,
  parameter int OUTSTND   = OUTSTND_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AXI_INADR-1:0]       AXI_ADDR,
  input  logic [7:0]                 AXI_ALEN,
  input  logic                       AXI_AVALID,
  output logic                       AXI_AREADY,
  input  logic                       AXI_VALID,
  output logic                       AXI_READY,
  output logic                       AXI_LAST,
  input  logic [TILES-1:0]           tile_AXI_AREADY,
  input  logic [TILES-1:0]           tile_AXI_READY,
  output logic [TILES-1:0]           tile_AXI_AVALID,
  output logic [TILES-1:0]           tile_AXI_VALID,
  output logic                       dec_err,
  output logic [$clog2(OUTSTND):0]   outstanding
);

  localparam logic [ADDR_TILE:0] TILES_LIM = (ADDR_TILE + 1)'(TILES);

  logic [ADDR_TILE-1:0] idx_s;
  logic                 unmapped_s;
  logic                 full_s;
  logic                 empty_s;
  ost_entry_t           head_s;
  logic [ADDR_TILE-1:0] head_idx_s;
  logic                 addr_hs_s;
  logic                 data_hs_s;
  logic                 pop_s;
  logic [7:0]           beat_r;
  logic                 dec_err_r;

  assign idx_s      = AXI_ADDR[AXI_INADR-1 -: ADDR_TILE];
  assign unmapped_s = ({1'b0, idx_s} >= TILES_LIM);
  assign head_idx_s = head_s.idx[ADDR_TILE-1:0];

  // Address-side routing: only a mapped tile sees AVALID; unmapped
  // addresses are accepted by the router itself.
  always_comb begin
    tile_AXI_AVALID = {TILES{1'b0}};
    AXI_AREADY      = 1'b0;
    if (full_s) begin
      AXI_AREADY = 1'b0;
    end else if (unmapped_s) begin
      AXI_AREADY = 1'b1;
    end else begin
      AXI_AREADY             = tile_AXI_AREADY[idx_s];
      tile_AXI_AVALID[idx_s] = AXI_AVALID;
    end
  end

  // Data-side routing follows the queue head; unmapped heads are sunk.
  always_comb begin
    tile_AXI_VALID = {TILES{1'b0}};
    AXI_READY      = 1'b0;
    AXI_LAST       = 1'b0;
    if (empty_s) begin
      AXI_READY = 1'b0;
    end else if (head_s.unmapped) begin
      AXI_READY = 1'b1;
      AXI_LAST  = (beat_r == head_s.alen);
    end else begin
      AXI_READY                  = tile_AXI_READY[head_idx_s];
      tile_AXI_VALID[head_idx_s] = AXI_VALID;
      AXI_LAST                   = (beat_r == head_s.alen);
    end
  end

  assign addr_hs_s = AXI_AVALID & AXI_AREADY;
  assign data_hs_s = AXI_VALID & AXI_READY;
  assign pop_s     = data_hs_s & AXI_LAST;

  axi_ux_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (OUTSTND)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (addr_hs_s),
    .din   (make_entry(IDX_W'(idx_s), AXI_ALEN, unmapped_s)),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (outstanding)
  );

  // Beat counter for the head burst and the decode-error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_r    <= 8'd0;
      dec_err_r <= 1'b0;
    end else begin
      dec_err_r <= addr_hs_s & unmapped_s;
      if (pop_s) begin
        beat_r <= 8'd0;
      end else if (data_hs_s) begin
        beat_r <= beat_r + 8'd1;
      end else begin
        beat_r <= beat_r;
      end
    end
  end

  assign dec_err = dec_err_r;

endmodule

// File: tb/tb_axi_ux_route.sv
module tb_axi_ux_route;

  localparam int TILES   = 12;
  localparam int OUTSTND = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] addr;
  logic [7:0]  alen;
  logic        avalid;
  logic        aready;
  logic        valid;
  logic        ready;
  logic        last;
  logic [11:0] tile_aready;
  logic [11:0] tile_ready;
  logic [11:0] tavalid;
  logic [11:0] tvalid;
  logic        dec_err;
  logic [2:0]  outstanding;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_ux_route #(
    .AXI_INADR (12),
    .ADDR_TILE (4),
    .TILES     (TILES),
    .OUTSTND   (OUTSTND)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .AXI_ADDR        (addr),
    .AXI_ALEN        (alen),
    .AXI_AVALID      (avalid),
    .AXI_AREADY      (aready),
    .AXI_VALID       (valid),
    .AXI_READY       (ready),
    .AXI_LAST        (last),
    .tile_AXI_AREADY (tile_aready),
    .tile_AXI_READY  (tile_ready),
    .tile_AXI_AVALID (tavalid),
    .tile_AXI_VALID  (tvalid),
    .dec_err         (dec_err),
    .outstanding     (outstanding)
  );

  // Reference model: a queue of outstanding bursts plus the beat position in
  // the oldest one.
  typedef struct {
    int idx;
    int alen;
    bit unm;
  } ent_t;

  ent_t q[$];
  int   beat     = 0;
  bit   dec_pend = 0;
  bit   exp_aready, exp_ready, exp_last, exp_unm;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  alen;
    logic        avalid;
    logic        valid;
    logic        aready;
    logic [11:0] tavalid;
    logic        ready;
    logic [11:0] tvalid;
    logic        last;
    logic [2:0]  outst;
    logic        dec;
  } vec_t;

  vec_t tbl[12];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Compare all DUT outputs against the model at the falling edge.
  task automatic model_check();
    int          a_idx;
    bit          full, empty;
    logic [11:0] e_tav, e_tv;
    @(negedge clk);
    a_idx   = int'(addr[11:8]);
    exp_unm = (a_idx >= TILES);
    full    = (q.size() == OUTSTND);
    empty   = (q.size() == 0);
    e_tav   = 12'h000;
    e_tv    = 12'h000;
    if (full) exp_aready = 1'b0;
    else if (exp_unm) exp_aready = 1'b1;
    else exp_aready = tile_aready[a_idx];
    if (avalid && !full && !exp_unm) e_tav[a_idx] = 1'b1;
    if (empty) begin
      exp_ready = 1'b0;
      exp_last  = 1'b0;
    end else begin
      exp_ready = q[0].unm ? 1'b1 : tile_ready[q[0].idx];
      exp_last  = (beat == q[0].alen);
      if (valid && !q[0].unm) e_tv[q[0].idx] = 1'b1;
    end
    chk("aready", 32'(aready), 32'(exp_aready));
    chk("tile_avalid", 32'(tavalid), 32'(e_tav));
    chk("ready", 32'(ready), 32'(exp_ready));
    chk("tile_valid", 32'(tvalid), 32'(e_tv));
    chk("last", 32'(last), 32'(exp_last));
    chk("outstanding", 32'(outstanding), 32'(q.size()));
    chk("dec_err", 32'(dec_err), 32'(dec_pend));
  endtask

  // Advance one clock and update the model with the handshakes that occurred.
  task automatic advance();
    bit   a_hs, d_hs;
    ent_t e;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      beat     = 0;
      dec_pend = 0;
    end else begin
      a_hs     = avalid && exp_aready;
      d_hs     = valid && exp_ready;
      dec_pend = a_hs && exp_unm;
      if (d_hs && exp_last) begin
        void'(q.pop_front());
        beat = 0;
      end else if (d_hs) begin
        beat++;
      end
      if (a_hs) begin
        e.idx  = int'(addr[11:8]);
        e.alen = int'(alen);
        e.unm  = exp_unm;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic step();
    model_check();
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int hs;
    int n;

    //           addr    alen avv vld ardy tavalid ready tvalid  last out dec
    tbl[0]  = '{12'h300, 8'd0, 1, 0, 1, 12'h008, 0, 12'h000, 0, 3'd0, 0};
    tbl[1]  = '{12'h300, 8'd0, 0, 1, 1, 12'h000, 1, 12'h008, 1, 3'd1, 0};
    tbl[2]  = '{12'h300, 8'd0, 0, 0, 1, 12'h000, 0, 12'h000, 0, 3'd0, 0};
    tbl[3]  = '{12'h200, 8'd1, 1, 0, 1, 12'h004, 0, 12'h000, 0, 3'd0, 0};
    tbl[4]  = '{12'h900, 8'd0, 1, 1, 1, 12'h200, 1, 12'h004, 0, 3'd1, 0};
    tbl[5]  = '{12'h900, 8'd0, 0, 1, 1, 12'h000, 1, 12'h004, 1, 3'd2, 0};
    tbl[6]  = '{12'h900, 8'd0, 0, 1, 1, 12'h000, 1, 12'h200, 1, 3'd1, 0};
    tbl[7]  = '{12'h900, 8'd0, 0, 0, 1, 12'h000, 0, 12'h000, 0, 3'd0, 0};
    tbl[8]  = '{12'hE00, 8'd1, 1, 0, 1, 12'h000, 0, 12'h000, 0, 3'd0, 0};
    tbl[9]  = '{12'hE00, 8'd1, 0, 1, 1, 12'h000, 1, 12'h000, 0, 3'd1, 1};
    tbl[10] = '{12'hE00, 8'd1, 0, 1, 1, 12'h000, 1, 12'h000, 1, 3'd1, 0};
    tbl[11] = '{12'hE00, 8'd1, 0, 0, 1, 12'h000, 0, 12'h000, 0, 3'd0, 0};

    rst_n       = 1'b0;
    addr        = 12'h000;
    alen        = 8'd0;
    avalid      = 1'b0;
    valid       = 1'b0;
    tile_aready = 12'hFFF;
    tile_ready  = 12'hFFF;
    @(posedge clk);
    #1;
    q.delete();
    step();
    step();
    rst_n = 1'b1;

    // Directed single-beat, ordering and unmapped vectors.
    for (int i = 0; i < 12; i++) begin
      addr   = tbl[i].addr;
      alen   = tbl[i].alen;
      avalid = tbl[i].avalid;
      valid  = tbl[i].valid;
      model_check();
      chk($sformatf("vec%0d_aready", i), 32'(aready), 32'(tbl[i].aready));
      chk($sformatf("vec%0d_tavalid", i), 32'(tavalid), 32'(tbl[i].tavalid));
      chk($sformatf("vec%0d_ready", i), 32'(ready), 32'(tbl[i].ready));
      chk($sformatf("vec%0d_tvalid", i), 32'(tvalid), 32'(tbl[i].tvalid));
      chk($sformatf("vec%0d_last", i), 32'(last), 32'(tbl[i].last));
      chk($sformatf("vec%0d_outst", i), 32'(outstanding), 32'(tbl[i].outst));
      chk($sformatf("vec%0d_dec", i), 32'(dec_err), 32'(tbl[i].dec));
      advance();
    end

    // Burst to tile 5 with its READY toggling.
    addr = 12'h500; alen = 8'd3; avalid = 1'b1; valid = 1'b0;
    step();
    avalid = 1'b0; valid = 1'b1;
    hs = 0;
    n  = 0;
    while (hs < 4 && n < 20) begin
      tile_ready = 12'hFFF;
      tile_ready[5] = n[0];
      model_check();
      if (tvalid[5] && tile_ready[5] && ready) begin
        hs++;
        chk("burst_last", 32'(last), 32'(hs == 4));
      end
      advance();
      n++;
    end
    chk("burst_handshakes", 32'(hs), 32'd4);
    valid = 1'b0; tile_ready = 12'hFFF;
    step();
    chk("burst_popped", 32'(outstanding), 32'd0);

    // Five addresses with no data: fifth waits for the first pop.
    valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      addr = 12'(i << 8); alen = 8'd0; avalid = 1'b1;
      model_check();
      if (i == 4) chk("full_aready", 32'(aready), 32'd0);
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      model_check();
      chk("full_hold_aready", 32'(aready), 32'd0);
      chk("full_hold_outst", 32'(outstanding), 32'd4);
      advance();
    end
    valid = 1'b1;
    n = 0;
    while ((q.size() != 0 || avalid) && n < 30) begin
      model_check();
      if (exp_aready) begin
        advance();
        avalid = 1'b0;
      end else begin
        advance();
      end
      n++;
    end
    chk("full_drained", 32'(q.size()), 32'd0);
    valid = 1'b0;
    step();

    // Reset in the middle of a 4-beat burst.
    addr = 12'h100; alen = 8'd3; avalid = 1'b1;
    step();
    avalid = 1'b0; valid = 1'b1;
    step();
    step();
    valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_check();
    chk("rst_outst", 32'(outstanding), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    advance();
    addr = 12'h100; alen = 8'd3; avalid = 1'b1;
    step();
    avalid = 1'b0; valid = 1'b1;
    model_check();
    chk("rst_new_first_last", 32'(last), 32'd0);
    advance();
    for (int i = 0; i < 3; i++) step();
    valid = 1'b0;
    step();
    chk("rst_new_done", 32'(outstanding), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst_n       = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      addr        = {4'($urandom_range(0, 15)), 8'($urandom)};
      alen        = 8'($urandom_range(0, 3));
      avalid      = 1'($urandom);
      valid       = 1'($urandom);
      tile_aready = 12'($urandom) | 12'($urandom);
      tile_ready  = 12'($urandom) | 12'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_ux_route.md
AXI_UX_ROUTE -- requirements
Module: axi_ux_route

Interface
REQ-001 SHALL have parameter AXI_INADR, default 12, address bus width.
REQ-002 SHALL have parameter ADDR_TILE, default 4, tile-index field width, taken from AXI_ADDR[AXI_INADR-1 -: ADDR_TILE].
REQ-003 SHALL have parameter TILES, default 16, number of tile ports (TILES <= 2**ADDR_TILE).
REQ-004 SHALL have parameter OUTSTND, default 4, max accepted-but-unfinished transactions (power of 2, >=2).
REQ-005 SHALL have ports: clk in 1 clock; rst_n in 1 reset (one clock; reset is synchronous and active-low).
REQ-006 SHALL have ports: AXI_ADDR in AXI_INADR address; AXI_ALEN in 8 beats-1; AXI_AVALID in 1; AXI_AREADY out 1.
REQ-007 SHALL have ports: AXI_VALID in 1 data valid; AXI_READY out 1 data ready; AXI_LAST out 1 final beat of current burst.
REQ-008 SHALL have ports: tile_AXI_AREADY in TILES; tile_AXI_READY in TILES; tile_AXI_AVALID out TILES; tile_AXI_VALID out TILES.
REQ-009 SHALL have ports: dec_err out 1 one-cycle pulse on unmapped address accept; outstanding out $clog2(OUTSTND)+1 count.

Function
REQ-010 SHALL decode idx = tile field of AXI_ADDR; unmapped when idx >= TILES.
REQ-011 SHALL assert tile_AXI_AVALID[idx] = AXI_AVALID & !full & mapped, combinationally; all other bits 0.
REQ-012 SHALL drive AXI_AREADY = !full & (unmapped | tile_AXI_AREADY[idx]).
REQ-013 SHALL, on address handshake (AXI_AVALID & AXI_AREADY), push {idx, AXI_ALEN, unmapped} into the outstanding FIFO.
REQ-014 SHALL block push while full, even if a pop occurs in the same cycle.
REQ-015 SHALL route data to the FIFO head only: tile_AXI_VALID[head.idx] = AXI_VALID & !empty & !head.unmapped.
REQ-016 SHALL drive AXI_READY = !empty & (head.unmapped | tile_AXI_READY[head.idx]); 0 when empty.
REQ-017 SHALL sink unmapped bursts locally: READY=1 per beat, no tile_AXI_VALID bit asserted.
REQ-018 SHALL keep beat counter, cleared at pop, incremented per data handshake; AXI_LAST = !empty & (beat == head.alen).
REQ-019 SHALL pop the FIFO on the data handshake where AXI_LAST=1; counter returns to 0 same edge.
REQ-020 SHALL make data of a newly accepted address forwardable no earlier than the cycle after the address handshake.
REQ-021 SHALL, on simultaneous push and pop with FIFO neither full nor empty, keep outstanding unchanged and preserve order.
REQ-022 SHALL wrap FIFO pointers modulo OUTSTND; full = (count == OUTSTND), empty = (count == 0).
REQ-023 SHALL pulse dec_err for exactly the cycle after an unmapped address handshake.
REQ-024 SHALL accept AXI_ALEN=0 (single beat): LAST asserted on the first beat.

Reset
REQ-025 SHALL, while rst_n=0 at clk edge, clear FIFO pointers, count, beat counter and dec_err.
REQ-026 SHALL drive during/after reset: AXI_AREADY=0 only if full (so 1 when a tile/unmapped ready), AXI_READY=0, AXI_LAST=0, tile_AXI_VALID=0, outstanding=0, dec_err=0.
REQ-027 SHALL discard in-flight bursts on reset mid-operation; no partial beat state persists.

Structure
REQ-028 SHALL place the outstanding-entry struct (idx, alen, unmapped) and default widths in shared package axi_ux_pkg.
REQ-029 SHALL implement the ordered queue as sub-module axi_ux_fifo (parametrised width/depth, push/pop/full/empty/count).
REQ-030 SHALL be synthesizable, single clock domain, no latches.

Verification
REQ-031 Single beat: addr 0x300, ALEN=0, tiles ready -> tile_AXI_AVALID=0x0008, next cycle VALID -> tile_AXI_VALID=0x0008, LAST=1, outstanding 1->0.
REQ-032 Burst: addr 0x500, ALEN=3, tile 5 READY toggling -> 4 handshakes to tile 5 only, LAST on 4th, pop after.
REQ-033 Ordering: addr tile 2 ALEN=1 then tile 9 ALEN=0 -> beats 1-2 to tile 2, beat 3 to tile 9.
REQ-034 Full: OUTSTND=4, 5 addresses, no data -> AREADY=0 on 5th until first pop, outstanding=4 held.
REQ-035 Unmapped: TILES=12, addr 0xE00 ALEN=1 -> no tile_AXI_AVALID, dec_err one pulse, 2 beats sunk with READY=1.
REQ-036 Reset mid-burst: rst_n low after beat 2 of ALEN=3 -> outstanding=0, READY=0, next burst starts at beat 0.
